ex_issue_sequencer: RTL and testbench

EX_ISSUE_SEQUENCER -- requirements
Module: ex_issue_sequencer

---
 rtl/ex_issue_sequencer_if.sv | 26 ++
 rtl/ex_issue_sequencer.sv | 123 ++++++++++++
 tb/tb_ex_issue_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_issue_sequencer_if.sv
// Handshake bundle between the ID stage, the EX issue sequencer and the MEM stage.
// The master side drives operations in and consumes results; the slave is the sequencer.
interface ex_issue_sequencer_if #(
    parameter int XLEN = 32
);
    logic            inValid;
    logic            inReady;
    logic [7:0]      exOp;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            flush;
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output inValid, exOp, opA, opB, flush, outReady,
        input  inReady, outValid, result, busy
    );

    modport slave (
        input  inValid, exOp, opA, opB, flush, outReady,
        output inReady, outValid, result, busy
    );
endinterface

// File: rtl/ex_issue_sequencer.sv
// EX-stage issue sequencer: single-cycle ALU ops plus iterative one-bit-per-cycle shifts,
// with a valid/ready handshake on both sides and a flush that discards in-flight work.
module ex_issue_sequencer #(
    parameter int XLEN = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    ex_issue_sequencer_if.slave seq_if
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            shr_q, shr_d;
    logic            sra_q, sra_d;

    logic            work_en, cpt_sel, is_shift, in_ready, transfer;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_res, acc_step;

    assign work_en  = seq_if.exOp[0];
    assign cpt_sel  = seq_if.exOp[1];
    assign alu_op   = seq_if.exOp[7:4];
    assign is_shift = work_en && !cpt_sel &&
                      (alu_op == 4'b0001 || alu_op == 4'b0101 || alu_op == 4'b1101);

    // A pending flush blocks acceptance even when the MEM stage is draining DONE.
    assign in_ready = rst_n && !seq_if.flush &&
                      (state_q == IDLE || (state_q == DONE && seq_if.outReady));
    assign transfer = seq_if.inValid && in_ready;

    always_comb begin
        alu_res = '0;
        if (!work_en) begin
            alu_res = '0;
        end else if (cpt_sel) begin
            alu_res = seq_if.opB;
        end else begin
            case (alu_op)
                4'b0000: alu_res = seq_if.opA + seq_if.opB;
                4'b1000: alu_res = seq_if.opA - seq_if.opB;
                4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(seq_if.opA) < $signed(seq_if.opB))};
                4'b0011: alu_res = {{(XLEN-1){1'b0}}, (seq_if.opA < seq_if.opB)};
                4'b0100: alu_res = seq_if.opA ^ seq_if.opB;
                4'b0110: alu_res = seq_if.opA | seq_if.opB;
                4'b0111: alu_res = seq_if.opA & seq_if.opB;
                4'b1111: alu_res = seq_if.opA + XLEN'(4);
                default: alu_res = '0;
            endcase
        end
    end

    always_comb begin
        acc_step = {acc_q[XLEN-2:0], 1'b0};
        if (shr_q) begin
            acc_step = {(sra_q ? acc_q[XLEN-1] : 1'b0), acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        shr_d    = shr_q;
        sra_d    = sra_q;
        if (transfer) begin
            shr_d = alu_op[2];
            sra_d = alu_op[3];
            if (is_shift && seq_if.opB[4:0] != 5'd0) begin
                state_d = SHIFT;
                acc_d   = seq_if.opA;
                cnt_d   = seq_if.opB[4:0];
            end else begin
                state_d  = DONE;
                result_d = is_shift ? seq_if.opA : alu_res;
            end
        end else if (seq_if.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                SHIFT: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d  = DONE;
                        result_d = acc_step;
                    end
                end
                DONE:    if (seq_if.outReady) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            shr_q    <= 1'b0;
            sra_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            shr_q    <= shr_d;
            sra_q    <= sra_d;
        end
    end

    // Status outputs are gated by rst_n so they read inactive throughout reset.
    assign seq_if.inReady  = in_ready;
    assign seq_if.outValid = rst_n && (state_q == DONE);
    assign seq_if.busy     = rst_n && (state_q != IDLE);
    assign seq_if.result   = result_q;
endmodule

// File: tb/tb_ex_issue_sequencer.sv
// Directed and randomized bench for ex_issue_sequencer against a behavioural result/latency model.
module tb_ex_issue_sequencer;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    ex_issue_sequencer_if #(.XLEN(XLEN)) bus ();

    ex_issue_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic [3:0] alu, input logic we, input logic cpt);
        return {alu, 2'b00, cpt, we};
    endfunction

    function automatic logic is_shift_op(input logic [7:0] op);
        return op[0] && !op[1] && (op[7:4] == 4'h1 || op[7:4] == 4'h5 || op[7:4] == 4'hD);
    endfunction

    function automatic logic [31:0] model_result(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        if (!op[0]) return 32'h0;
        if (op[1]) return b;
        case (op[7:4])
            4'h0: return a + b;
            4'h8: return a - b;
            4'h2: return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            4'h3: return (a < b) ? 32'h1 : 32'h0;
            4'h4: return a ^ b;
            4'h6: return a | b;
            4'h7: return a & b;
            4'hF: return a + 32'd4;
            4'h1: return a << sh;
            4'h5: return a >> sh;
            4'hD: return $unsigned($signed(a) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_latency(input logic [7:0] op, input logic [31:0] b);
        return is_shift_op(op) ? 1 + int'(b[4:0]) : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, wait for its result, hold back-pressure for `stall` cycles, retire it.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [31:0] exp_r;
        int          exp_lat, lat;
        logic        seen;
        exp_r   = model_result(op, a, b);
        exp_lat = model_latency(op, b);
        bus.inValid  = 1'b1;
        bus.exOp     = op;
        bus.opA      = a;
        bus.opB      = b;
        bus.outReady = (stall == 0);
        @(negedge clk);
        check({tag, ":inReady"}, 32'(bus.inReady), 32'h1);
        cycle();
        bus.inValid = 1'b0;
        bus.exOp    = 8'($urandom);
        bus.opA     = $urandom;
        bus.opB     = $urandom;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            lat++;
            @(negedge clk);
            if (bus.outValid) begin
                seen = 1'b1;
            end else begin
                check({tag, ":busy"}, 32'(bus.busy), 32'h1);
                cycle();
            end
        end
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":result"}, bus.result, exp_r);
        for (int s = 0; s < stall; s++) begin
            cycle();
            @(negedge clk);
            check({tag, ":hold_valid"}, 32'(bus.outValid), 32'h1);
            check({tag, ":hold_result"}, bus.result, exp_r);
            check({tag, ":hold_inReady"}, 32'(bus.inReady), 32'h0);
        end
        if (stall > 0) begin
            cycle();
            bus.outReady = 1'b1;
            @(negedge clk);
            check({tag, ":retire_valid"}, 32'(bus.outValid), 32'h1);
        end
        cycle();
        @(negedge clk);
        check({tag, ":retired"}, 32'(bus.outValid), 32'h0);
        cycle();
    endtask

    initial begin
        logic       any_valid;
        logic [3:0] codes [12];
        logic [7:0] op;
        logic [31:0] a, b;
        codes = '{4'h0, 4'h8, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hF, 4'h1, 4'h5, 4'hD, 4'hA};

        rst_n        = 1'b0;
        bus.inValid  = 1'b0;
        bus.exOp     = 8'h0;
        bus.opA      = 32'h0;
        bus.opB      = 32'h0;
        bus.flush    = 1'b0;
        bus.outReady = 1'b0;
        cycle();
        cycle();
        bus.inValid = 1'b1;
        @(negedge clk);
        check("reset:outValid", 32'(bus.outValid), 32'h0);
        check("reset:busy", 32'(bus.busy), 32'h0);
        check("reset:inReady", 32'(bus.inReady), 32'h0);
        check("reset:result", bus.result, 32'h0);
        cycle();
        bus.inValid = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);
        check("idle:inReady", 32'(bus.inReady), 32'h1);
        check("idle:busy", 32'(bus.busy), 32'h0);
        cycle();

        // Directed cases
        run_op("add_wrap", mk(4'h0, 1'b1, 1'b0), 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sra4", mk(4'hD, 1'b1, 1'b0), 32'h8000_0000, 32'h24, 0);
        run_op("sub_bp", mk(4'h8, 1'b1, 1'b0), 32'd5, 32'd7, 3);
        run_op("workEn0", mk(4'h0, 1'b0, 1'b0), 32'h1234, 32'h5678, 0);
        run_op("cpt", mk(4'h0, 1'b1, 1'b1), 32'hDEAD_BEEF, 32'h1234_5000, 0);
        run_op("pc4", mk(4'hF, 1'b1, 1'b0), 32'h100, 32'h0, 0);
        run_op("code1010", mk(4'hA, 1'b1, 1'b0), 32'hFFFF, 32'h1, 0);
        run_op("sll0", mk(4'h1, 1'b1, 1'b0), 32'hABCD_0001, 32'hFFFF_FFE0, 0);
        run_op("srl31", mk(4'h5, 1'b1, 1'b0), 32'h8000_0000, 32'h1F, 1);
        run_op("slt_neg", mk(4'h2, 1'b1, 1'b0), 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sltu_neg", mk(4'h3, 1'b1, 1'b0), 32'hFFFF_FFFF, 32'h1, 0);

        // Back-to-back XOR, OR, AND with outReady held high
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        bus.exOp = mk(4'h4, 1'b1, 1'b0); bus.opA = 32'hF0F0_1234; bus.opB = 32'h0FF0_4321;
        cycle();
        bus.exOp = mk(4'h6, 1'b1, 1'b0); bus.opA = 32'h1100_0011; bus.opB = 32'h0022_2200;
        @(negedge clk);
        check("b2b:xor_valid", 32'(bus.outValid), 32'h1);
        check("b2b:xor_result", bus.result, 32'hFF00_5115);
        check("b2b:inReady", 32'(bus.inReady), 32'h1);
        cycle();
        bus.exOp = mk(4'h7, 1'b1, 1'b0); bus.opA = 32'hFF00_FF00; bus.opB = 32'h0F0F_0F0F;
        @(negedge clk);
        check("b2b:or_valid", 32'(bus.outValid), 32'h1);
        check("b2b:or_result", bus.result, 32'h1122_2211);
        cycle();
        bus.inValid = 1'b0;
        @(negedge clk);
        check("b2b:and_valid", 32'(bus.outValid), 32'h1);
        check("b2b:and_result", bus.result, 32'h0F00_0F00);
        cycle();
        @(negedge clk);
        check("b2b:drained", 32'(bus.outValid), 32'h0);
        cycle();

        // Flush in the 2nd SHIFT cycle of sll by 10
        bus.inValid = 1'b1;
        bus.exOp = mk(4'h1, 1'b1, 1'b0); bus.opA = 32'h1; bus.opB = 32'd10;
        cycle();
        bus.inValid = 1'b0;
        cycle();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush:inReady", 32'(bus.inReady), 32'h0);
        check("flush:busy_before", 32'(bus.busy), 32'h1);
        cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush:busy_after", 32'(bus.busy), 32'h0);
        any_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            any_valid = any_valid | bus.outValid;
            cycle();
        end
        check("flush:no_valid", 32'(any_valid), 32'h0);

        // Flush together with outReady and a new request while in DONE
        bus.inValid = 1'b1; bus.outReady = 1'b0;
        bus.exOp = mk(4'h0, 1'b1, 1'b0); bus.opA = 32'd1; bus.opB = 32'd2;
        cycle();
        bus.flush = 1'b1; bus.outReady = 1'b1;
        bus.opA = 32'd100;
        @(negedge clk);
        check("flushdone:valid", 32'(bus.outValid), 32'h1);
        check("flushdone:inReady", 32'(bus.inReady), 32'h0);
        cycle();
        bus.flush = 1'b0; bus.inValid = 1'b0;
        @(negedge clk);
        check("flushdone:cleared", 32'(bus.outValid), 32'h0);
        check("flushdone:no_xfer", 32'(bus.busy), 32'h0);
        cycle();

        // Reset in the middle of a long shift
        bus.inValid = 1'b1;
        bus.exOp = mk(4'hD, 1'b1, 1'b0); bus.opA = 32'h8765_4321; bus.opB = 32'd20;
        cycle();
        bus.inValid = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst:busy", 32'(bus.busy), 32'h0);
        check("midrst:inReady", 32'(bus.inReady), 32'h0);
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst:result", bus.result, 32'h0);
        check("midrst:idle", 32'(bus.busy), 32'h0);
        any_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            any_valid = any_valid | bus.outValid;
            cycle();
        end
        check("midrst:no_valid", 32'(any_valid), 32'h0);

        // Randomized operations against the model
        for (int i = 0; i < 150; i++) begin
            op = {codes[$urandom_range(0, 11)], 2'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) != 0)};
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 7))};
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d", i), op, a, b, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
